// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable framing and a small input FIFO.
// Queued words are sent back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_valid,
  input  logic [DATA_BITS-1:0]          din,
  output logic                          din_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(BIT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 tx_q, tx_d;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 tick;
  logic [DATA_BITS-1:0] head;

  assign full  = (cnt_q == C_FULL);
  assign empty = (cnt_q == '0);
  assign push  = din_valid && !full;
  assign tick  = (timer_q == T_LAST);
  assign head  = mem_q[rptr_q];

  assign din_ready  = !full;
  assign tx_out     = tx_q;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != IDLE) || !empty;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    if (state_q == IDLE || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == D_LAST) begin
            bitcnt_d = '0;
            state_d  = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d  = STOP;
          bitcnt_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bitcnt_q == S_LAST) begin
            bitcnt_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shreg_d = head;
      par_d   = (PARITY_MODE == 2) ? ~^head : ^head;
    end
  end

  // Line level follows the next state so tx_out is a plain flop output.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      timer_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      timer_q  <= timer_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four framing configs at 10 clocks per bit.
// Frame tables plus FIFO, reset and write/pop corner sequences.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv   [4];
  logic [8:0] din  [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       bsy  [4];
  logic [2:0] cnt  [4];

  int cyc = 0;
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(
    .CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_even (
    .clk(clk), .rst_n(rst_n), .din_valid(dv[0]), .din(din[0][7:0]),
    .din_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]),
    .fifo_count(cnt[0])
  );

  uart_tx_fifo #(
    .CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_odd (
    .clk(clk), .rst_n(rst_n), .din_valid(dv[1]), .din(din[1][7:0]),
    .din_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]),
    .fifo_count(cnt[1])
  );

  uart_tx_fifo #(
    .CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_none (
    .clk(clk), .rst_n(rst_n), .din_valid(dv[2]), .din(din[2][7:0]),
    .din_ready(rdy[2]), .tx_out(tx[2]), .busy(bsy[2]),
    .fifo_count(cnt[2])
  );

  uart_tx_fifo #(
    .CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(7),
    .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_7b2s (
    .clk(clk), .rst_n(rst_n), .din_valid(dv[3]), .din(din[3][6:0]),
    .din_ready(rdy[3]), .tx_out(tx[3]), .busy(bsy[3]),
    .fifo_count(cnt[3])
  );

  typedef struct {
    int         k;
    logic [8:0] d;
    string      pat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int err;
    int berr;
    logic e;
    @(negedge clk);
    dv[v.k] = 1'b1;
    din[v.k] = v.d;
    @(posedge clk);
    #1;
    dv[v.k] = 1'b0;
    din[v.k] = ~v.d;
    chk($sformatf("pre_start k%0d", v.k), int'(tx[v.k]), 1);
    berr = 0;
    for (int s = 0; s < v.pat.len(); s++) begin
      err = 0;
      e = (v.pat.getc(s) == "1");
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        if (tx[v.k] != e) err++;
        if (!bsy[v.k]) berr++;
      end
      chk($sformatf("slot k%0d d%0h s%0d", v.k, v.d, s), err, 0);
    end
    chk($sformatf("busy_frame k%0d", v.k), berr, 0);
    @(posedge clk);
    #1;
    chk($sformatf("end_idle k%0d", v.k),
        int'({tx[v.k], bsy[v.k]}), 2);
  endtask

  task automatic wr0(input logic [7:0] d);
    @(negedge clk);
    dv[0] = 1'b1;
    din[0] = {1'b0, d};
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
  endtask

  task automatic fill0(input logic [7:0] base, output int t_first);
    int  n;
    logic acc;
    n = 0;
    t_first = -1;
    for (int c = 0; c < 12 && n < 5; c++) begin
      @(negedge clk);
      dv[0] = 1'b1;
      din[0] = {1'b0, base + 8'(n)};
      acc = rdy[0];
      @(posedge clk);
      #1;
      if (acc) begin
        if (n == 0) t_first = cyc;
        n++;
      end
    end
    chk("fill_accepts", n, 5);
    chk("fill_ready_low", int'(rdy[0]), 0);
    chk("fill_count", int'(cnt[0]), 4);
    @(negedge clk);
    din[0] = {1'b0, base + 8'd5};
    @(posedge clk);
    #1;
    chk("full_no_accept", int'(cnt[0]), 4);
    dv[0] = 1'b0;
  endtask

  task automatic recv0(input int tk, output logic [7:0] d,
                       output int tfall, output logic ok,
                       output int cmid);
    logic found;
    logic st;
    logic pb;
    logic sp;
    found = 1'b0;
    tfall = -1;
    d = '0;
    cmid = -1;
    if (tk >= 0) begin
      while (cyc < tk + 5) begin
        @(posedge clk);
        #1;
      end
      found = 1'b1;
      tfall = tk;
    end else begin
      for (int i = 0; i < 400 && !found; i++) begin
        @(posedge clk);
        #1;
        if (tx[0] == 1'b0) begin
          found = 1'b1;
          tfall = cyc;
        end
      end
      repeat (5) begin
        @(posedge clk);
        #1;
      end
    end
    st = tx[0];
    for (int b = 0; b < 8; b++) begin
      repeat (10) begin
        @(posedge clk);
        #1;
      end
      d[b] = tx[0];
      if (b == 4) cmid = int'(cnt[0]);
    end
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    pb = tx[0];
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    sp = tx[0];
    ok = found && !st && (pb == ^d) && sp;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         tf;
    int         tprev;
    int         tfall;
    int         cm;
    int         err;
    logic [7:0] d;
    logic       ok;

    vecs[0] = '{k: 0, d: 9'h0A5, pat: "01010010101"};
    vecs[1] = '{k: 0, d: 9'h007, pat: "01110000011"};
    vecs[2] = '{k: 1, d: 9'h0A5, pat: "01010010111"};
    vecs[3] = '{k: 1, d: 9'h000, pat: "00000000011"};
    vecs[4] = '{k: 2, d: 9'h0A5, pat: "0101001011"};
    vecs[5] = '{k: 2, d: 9'h000, pat: "0000000001"};
    vecs[6] = '{k: 3, d: 9'h041, pat: "01000001011"};
    vecs[7] = '{k: 3, d: 9'h07F, pat: "01111111111"};

    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      din[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_tx k%0d", k), int'(tx[k]), 1);
      chk($sformatf("rst_busy k%0d", k), int'(bsy[k]), 0);
      chk($sformatf("rst_ready k%0d", k), int'(rdy[k]), 1);
      chk($sformatf("rst_count k%0d", k), int'(cnt[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    fill0(8'h01, tf);
    tprev = tf + 1;
    for (int f = 0; f < 5; f++) begin
      recv0((f == 0) ? tf + 1 : -1, d, tfall, ok, cm);
      chk($sformatf("q_data f%0d", f), int'(d), f + 1);
      chk($sformatf("q_frame f%0d", f), int'(ok), 1);
      chk($sformatf("q_count f%0d", f), cm, 4 - f);
      if (f > 0) begin
        chk($sformatf("q_gap f%0d", f), tfall - tprev, 110);
      end
      tprev = tfall;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("q_done", int'({tx[0], bsy[0], cnt[0]}), 8'b1000_0000 >> 3);

    fill0(8'h80, tf);
    while (cyc < tf + 156) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_count", int'(cnt[0]), 3);
    chk("rst_mid_busy", int'(bsy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", int'(tx[0]), 1);
    chk("arst_busy", int'(bsy[0]), 0);
    chk("arst_count", int'(cnt[0]), 0);
    chk("arst_ready", int'(rdy[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    err = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (!tx[0] || bsy[0] || cnt[0] != 3'd0) err++;
    end
    chk("post_rst_quiet", err, 0);

    wr0(8'h11);
    tf = cyc;
    wr0(8'h22);
    wr0(8'h33);
    chk("wp_count_pre", int'(cnt[0]), 2);
    do @(negedge clk); while (cyc != tf + 110);
    chk("wp_count_at", int'(cnt[0]), 2);
    dv[0] = 1'b1;
    din[0] = 9'h044;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    chk("wp_count_post", int'(cnt[0]), 2);
    recv0(tf + 111, d, tfall, ok, cm);
    chk("wp_b_data", int'(d), 8'h22);
    chk("wp_b_frame", int'(ok), 1);
    tprev = tfall;
    recv0(-1, d, tfall, ok, cm);
    chk("wp_c_data", int'(d), 8'h33);
    chk("wp_c_gap", tfall - tprev, 110);
    tprev = tfall;
    recv0(-1, d, tfall, ok, cm);
    chk("wp_d_data", int'(d), 8'h44);
    chk("wp_d_gap", tfall - tprev, 110);
    repeat (10) @(posedge clk);
    #1;
    chk("wp_idle", int'({tx[0], bsy[0]}), 2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
